// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one combinational alu4
// between two valid/ready requesters, with a tagged response channel.
module alu_share_ctrl #(
  parameter int DW         = 4,
  parameter int OPW        = 4,
  parameter int ALU_SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_x,
  input  logic [DW-1:0]  alu_y,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [DW-1:0]  resp_x,
  output logic [DW-1:0]  resp_y,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(ALU_SETTLE - 1);

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     cnt;
  logic           last_grant;
  logic           grant0;
  logic           grant1;
  logic           accept;
  logic           done;
  logic           fire;
  logic [DW-1:0]  sel_a;
  logic [DW-1:0]  sel_b;
  logic [OPW-1:0] sel_op;

  // On a tie the requester that did not win last time goes first.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;

  assign accept = req0_ready || req1_ready;
  assign done   = (state == WAIT) && (cnt == 4'd0);
  assign fire   = (state == RESP) && resp_valid && resp_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    sel_a  = req0_a;
    sel_b  = req0_b;
    sel_op = req0_op;
    unique case (1'b1)
      req1_ready: begin
        sel_a  = req1_a;
        sel_b  = req1_b;
        sel_op = req1_op;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (done)   state_nxt = RESP;
      RESP:    if (fire)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_x     <= '0;
      resp_y     <= '0;
    end else begin
      if (accept) begin
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        alu_op     <= sel_op;
        last_grant <= req1_ready;
        resp_id    <= req1_ready;
        cnt        <= SETTLE_M1;
      end
      if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (done) begin
        resp_x     <= alu_x;
        resp_y     <= alu_y;
        resp_valid <= 1'b1;
      end
      if (fire) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural alu4 model;
// a second instance runs with ALU_SETTLE=3.
module tb_alu_share_ctrl;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b, req0_op;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b, req1_op;
  logic [3:0] alu_a, alu_b, alu_op, alu_x, alu_y;
  logic       resp_valid, resp_ready, resp_id, busy;
  logic [3:0] resp_x, resp_y;

  logic       s3_req0_valid, s3_req0_ready;
  logic [3:0] s3_req0_a, s3_req0_b, s3_req0_op;
  logic       s3_req1_valid, s3_req1_ready;
  logic [3:0] s3_req1_a, s3_req1_b, s3_req1_op;
  logic [3:0] s3_alu_a, s3_alu_b, s3_alu_op;
  logic [3:0] s3_alu_x, s3_alu_y;
  logic       s3_resp_valid, s3_resp_ready;
  logic       s3_resp_id, s3_busy;
  logic [3:0] s3_resp_x, s3_resp_y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] x;
    logic [3:0] y;
  } vec_t;

  vec_t vecs[7];

  // Stand-in alu4: x depends on opcode, y is always a^b.
  function automatic logic [7:0] alu_f(
    input logic [3:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] x;
    case (op)
      4'd0:    x = a + b;
      4'd1:    x = a - b;
      4'd8:    x = a & b;
      4'd9:    x = a | b;
      4'd11:   x = {3'b0, a > b};
      4'd13:   x = {3'b0, a == b};
      4'd14,
      4'd15:   x = ~a;
      default: x = a;
    endcase
    return {x, a ^ b};
  endfunction

  assign {alu_x, alu_y}       = alu_f(alu_op, alu_a, alu_b);
  assign {s3_alu_x, s3_alu_y} = alu_f(s3_alu_op, s3_alu_a, s3_alu_b);

  alu_share_ctrl #(.DW(4), .OPW(4), .ALU_SETTLE(1)) u0 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_x(alu_x), .alu_y(alu_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_x(resp_x), .resp_y(resp_y),
    .busy(busy)
  );

  alu_share_ctrl #(.DW(4), .OPW(4), .ALU_SETTLE(3)) u3 (
    .clk(clk), .rst(rst),
    .req0_valid(s3_req0_valid), .req0_ready(s3_req0_ready),
    .req0_a(s3_req0_a), .req0_b(s3_req0_b), .req0_op(s3_req0_op),
    .req1_valid(s3_req1_valid), .req1_ready(s3_req1_ready),
    .req1_a(s3_req1_a), .req1_b(s3_req1_b), .req1_op(s3_req1_op),
    .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_op(s3_alu_op),
    .alu_x(s3_alu_x), .alu_y(s3_alu_y),
    .resp_valid(s3_resp_valid), .resp_ready(s3_resp_ready),
    .resp_id(s3_resp_id), .resp_x(s3_resp_x), .resp_y(s3_resp_y),
    .busy(s3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input logic id);
    int n;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_wait", id ? req1_ready : req0_ready, 1);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_wait", resp_valid, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
  endtask

  initial begin
    int cyc, last_cyc, nacc, seen;

    vecs[0] = '{0, 4'b1010, 4'b1100, 4'd8,  4'b1000, 4'b0110};
    vecs[1] = '{1, 4'b1001, 4'b1001, 4'd13, 4'b0001, 4'b0000};
    vecs[2] = '{0, 4'b0011, 4'b0101, 4'd0,  4'b1000, 4'b0110};
    vecs[3] = '{1, 4'b0101, 4'b0011, 4'd11, 4'b0001, 4'b0110};
    vecs[4] = '{0, 4'b1111, 4'b0001, 4'd0,  4'b0000, 4'b1110};
    vecs[5] = '{1, 4'b0110, 4'b0000, 4'd14, 4'b1001, 4'b0110};
    vecs[6] = '{0, 4'b0001, 4'b0010, 4'd15, 4'b1110, 4'b0011};

    rst = 0;
    idle_inputs();
    resp_ready = 1;
    s3_req0_valid = 0; s3_req0_a = 0; s3_req0_b = 0;
    s3_req0_op = 0;
    s3_req1_valid = 0; s3_req1_a = 0; s3_req1_b = 0;
    s3_req1_op = 0;
    s3_resp_ready = 0;

    #2 rst = 1;
    #1;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_x", resp_x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s3_busy", s3_busy, 0);
    @(negedge clk);
    rst = 0;

    // Single-op vectors, one requester at a time.
    foreach (vecs[i]) begin
      @(negedge clk);
      resp_ready = 1;
      if (vecs[i].id) begin
        req1_valid = 1; req1_a = vecs[i].a;
        req1_b = vecs[i].b; req1_op = vecs[i].op;
      end else begin
        req0_valid = 1; req0_a = vecs[i].a;
        req0_b = vecs[i].b; req0_op = vecs[i].op;
      end
      #1;
      chk("vec_busy_idle", busy, 0);
      wait_grant(vecs[i].id);
      chk("vec_other_ready",
          vecs[i].id ? req0_ready : req1_ready, 0);
      @(posedge clk);
      #1;
      idle_inputs();
      req0_a = 4'hf; req1_a = 4'hf; req0_op = 4'h3;
      chk("vec_alu_a", alu_a, vecs[i].a);
      chk("vec_alu_b", alu_b, vecs[i].b);
      chk("vec_alu_op", alu_op, vecs[i].op);
      chk("vec_early_resp", resp_valid, 0);
      chk("vec_busy", busy, 1);
      @(posedge clk);
      #1;
      chk("vec_resp_valid", resp_valid, 1);
      chk("vec_resp_id", resp_id, vecs[i].id);
      chk("vec_resp_x", resp_x, vecs[i].x);
      chk("vec_resp_y", resp_y, vecs[i].y);
      @(posedge clk);
      #1;
      chk("vec_resp_drop", resp_valid, 0);
      chk("vec_resp_hold", resp_x, vecs[i].x);
      chk("vec_alu_keep", alu_a, vecs[i].a);
      idle_inputs();
    end

    // Both valid continuously: strict alternation, 3-cycle interval.
    do_reset();
    req0_valid = 1; req0_a = 4'd3; req0_b = 4'd4;
    req0_op = 4'd0;
    req1_valid = 1; req1_a = 4'd6; req1_b = 4'd2;
    req1_op = 4'd1;
    resp_ready = 1;
    cyc = 0; last_cyc = 0; nacc = 0;
    while (nacc < 8 && cyc < 60) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("rr_one_hot", req0_ready && req1_ready, 0);
        chk("rr_order", req1_ready, nacc % 2);
        if (nacc > 0) chk("rr_interval", cyc - last_cyc, 3);
        last_cyc = cyc;
        nacc++;
      end
      if (nacc < 8) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rr_count", nacc, 8);
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rr_drain", busy, 0);

    // Response back-pressure; req0 waits and is served after.
    @(negedge clk);
    resp_ready = 0;
    req1_valid = 1; req1_a = 4'b1001; req1_b = 4'b1001;
    req1_op = 4'd13;
    #1;
    wait_grant(1);
    @(posedge clk);
    #1;
    req1_valid = 0;
    req0_valid = 1; req0_a = 4'b0010; req0_b = 4'b0011;
    req0_op = 4'd9;
    wait_resp();
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_valid", resp_valid, 1);
      chk("bp_id", resp_id, 1);
      chk("bp_x", resp_x, 4'b0001);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_busy", busy, 1);
    end
    resp_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_drop", resp_valid, 0);
    @(negedge clk);
    #1;
    chk("bp_queued_ready0", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 0;
    wait_resp();
    chk("bp_q_id", resp_id, 0);
    chk("bp_q_x", resp_x, 4'b0011);
    @(posedge clk);
    #1;

    // Reset mid-WAIT aborts; req0 wins the next tie.
    @(negedge clk);
    req0_valid = 1; req0_a = 4'hf; req0_b = 4'hf;
    req0_op = 4'd8;
    #1;
    wait_grant(0);
    @(posedge clk);
    #1;
    req0_valid = 0;
    chk("ab_in_wait", busy, 1);
    #2 rst = 1;
    #1;
    chk("ab_alu_a", alu_a, 0);
    chk("ab_alu_op", alu_op, 0);
    chk("ab_resp_x", resp_x, 0);
    chk("ab_resp_valid", resp_valid, 0);
    chk("ab_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    chk("ab_no_resp", seen, 0);
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("ab_ready0", req0_ready, 1);
    chk("ab_ready1", req1_ready, 0);
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;

    // ALU_SETTLE=3 instance.
    @(negedge clk);
    s3_req0_valid = 1; s3_req0_a = 4'b0101;
    s3_req0_b = 4'b0011; s3_req0_op = 4'd11;
    s3_resp_ready = 1;
    #1;
    chk("s3_ready", s3_req0_ready, 1);
    @(posedge clk);
    #1;
    s3_req0_valid = 0;
    s3_req0_a = 0;
    chk("s3_early_1", s3_resp_valid, 0);
    @(posedge clk);
    #1;
    chk("s3_early_2", s3_resp_valid, 0);
    @(posedge clk);
    #1;
    chk("s3_early_3", s3_resp_valid, 0);
    @(posedge clk);
    #1;
    chk("s3_resp_valid", s3_resp_valid, 1);
    chk("s3_resp_x", s3_resp_x, 4'b0001);
    chk("s3_resp_y", s3_resp_y, 4'b0110);
    @(posedge clk);
    #1;
    chk("s3_drop", s3_resp_valid, 0);
    chk("s3_alu_a_keep", s3_alu_a, 4'b0101);
    chk("s3_alu_b_keep", s3_alu_b, 4'b0011);

    // req0 pulses during RESP and is never served.
    @(negedge clk);
    resp_ready = 0;
    req1_valid = 1; req1_a = 4'b0010; req1_b = 4'b0001;
    req1_op = 4'd1;
    #1;
    wait_grant(1);
    @(posedge clk);
    #1;
    req1_valid = 0;
    wait_resp();
    @(negedge clk);
    req0_valid = 1;
    #1;
    chk("pulse_ready0", req0_ready, 0);
    @(negedge clk);
    req0_valid = 0;
    resp_ready = 1;
    @(posedge clk);
    #1;
    chk("pulse_drop", resp_valid, 0);
    chk("pulse_x", resp_x, 4'b0001);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (resp_valid || busy) seen++;
    end
    chk("pulse_no_resp", seen, 0);
    chk("pulse_id_held", resp_id, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
